// File: rtl/n64_pkg.sv
// Shared definitions for the N64 FlashRAM command decoder.
// Holds the MX29L1100-style command opcodes, the decoder mode enum and the
// bit positions inside the 4-bit status register.
package n64_pkg;

  // Command opcodes, taken from reg_wdata[31:24] of a command-register write.
  localparam logic [7:0] CMD_READ         = 8'hF0;
  localparam logic [7:0] CMD_STATUS       = 8'hE1;
  localparam logic [7:0] CMD_ID           = 8'h99;
  localparam logic [7:0] CMD_ERASE_SECTOR = 8'h4B;
  localparam logic [7:0] CMD_ERASE_CHIP   = 8'h3C;
  localparam logic [7:0] CMD_WRITE_BUF    = 8'hB4;
  localparam logic [7:0] CMD_ERASE_EXEC   = 8'h78;
  localparam logic [7:0] CMD_ERASE_EXEC2  = 8'hD2;
  localparam logic [7:0] CMD_EXEC         = 8'hA5;

  typedef enum logic [2:0] {
    ModeRead,
    ModeStatus,
    ModeId,
    ModeEraseSetup,
    ModeWriteBuffer,
    ModeBusy
  } e_flashram_mode;

  // Status register bit indices.
  localparam int unsigned STAT_WRITE_BUSY = 0;
  localparam int unsigned STAT_ERASE_BUSY = 1;
  localparam int unsigned STAT_WRITE_DONE = 2;
  localparam int unsigned STAT_ERASE_DONE = 3;

endpackage

// File: rtl/n64_flashram.sv
// FlashRAM command decoder between the PI register/buffer path and the SCB
// flashram handshake. Decodes command writes, tracks mode and status,
// forwards page-buffer writes to BRAM and raises flashram_pending until the
// controller pulses flashram_done.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   n64_reset               console reset (sync, active-high)
//   reg_write/address/wdata PI register write (addr 0 = status, 1 = command)
//   reg_rdata               status / ID read data (combinational)
//   buf_write/address/wdata PI page-buffer halfword write
//   flashram_pending/done   operation request / completion handshake
//   flashram_sector, flashram_sector_or_all, flashram_write_or_erase
//                           operation descriptor, stable while pending
//   flashram_read_mode      array readable by PI (mode is READ)
//   flashram_write/address/wdata  BRAM page-buffer write port
module n64_flashram
  import n64_pkg::*;
#(
  parameter logic [31:0] ID_HI = 32'h1111_8001,
  parameter logic [31:0] ID_LO = 32'h00C2_001E
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        n64_reset,
  input  logic        reg_write,
  input  logic        reg_address,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  input  logic        buf_write,
  input  logic [5:0]  buf_address,
  input  logic [15:0] buf_wdata,
  output logic        flashram_pending,
  input  logic        flashram_done,
  output logic [9:0]  flashram_sector,
  output logic        flashram_sector_or_all,
  output logic        flashram_write_or_erase,
  output logic        flashram_read_mode,
  output logic        flashram_write,
  output logic [5:0]  flashram_address,
  output logic [15:0] flashram_wdata
);

  e_flashram_mode mode_q, mode_d;
  logic [3:0]     status_q, status_d;
  logic           pending_q, pending_d;
  logic [9:0]     sector_q, sector_d;
  logic           sector_or_all_q, sector_or_all_d;
  logic           write_or_erase_q, write_or_erase_d;
  // Console reset seen while busy; applied once the operation completes.
  logic           reset_req_q, reset_req_d;

  logic [7:0] cmd;
  assign cmd = reg_wdata[31:24];

  logic unused_wdata;
  assign unused_wdata = ^reg_wdata[23:10];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q           <= ModeRead;
      status_q         <= '0;
      pending_q        <= 1'b0;
      sector_q         <= '0;
      sector_or_all_q  <= 1'b0;
      write_or_erase_q <= 1'b0;
      reset_req_q      <= 1'b0;
    end else begin
      mode_q           <= mode_d;
      status_q         <= status_d;
      pending_q        <= pending_d;
      sector_q         <= sector_d;
      sector_or_all_q  <= sector_or_all_d;
      write_or_erase_q <= write_or_erase_d;
      reset_req_q      <= reset_req_d;
    end
  end

  always_comb begin
    mode_d           = mode_q;
    status_d         = status_q;
    pending_d        = pending_q;
    sector_d         = sector_q;
    sector_or_all_d  = sector_or_all_q;
    write_or_erase_d = write_or_erase_q;
    reset_req_d      = reset_req_q;

    if (mode_q == ModeBusy) begin
      // Register writes are ignored while busy, so done always wins.
      if (n64_reset) reset_req_d = 1'b1;
      if (flashram_done) begin
        pending_d                 = 1'b0;
        status_d[STAT_WRITE_BUSY] = 1'b0;
        status_d[STAT_ERASE_BUSY] = 1'b0;
        if (write_or_erase_q) status_d[STAT_ERASE_DONE] = 1'b1;
        else                  status_d[STAT_WRITE_DONE] = 1'b1;
        mode_d = ModeStatus;
        if (reset_req_q || n64_reset) begin
          mode_d      = ModeRead;
          status_d    = '0;
          reset_req_d = 1'b0;
        end
      end
    end else if (n64_reset) begin
      mode_d   = ModeRead;
      status_d = '0;
    end else if (reg_write) begin
      if (!reg_address) begin
        status_d[STAT_WRITE_DONE] = 1'b0;
        status_d[STAT_ERASE_DONE] = 1'b0;
      end else begin
        case (cmd)
          CMD_READ:   mode_d = ModeRead;
          CMD_STATUS: mode_d = ModeStatus;
          CMD_ID:     mode_d = ModeId;
          CMD_ERASE_SECTOR: begin
            mode_d          = ModeEraseSetup;
            sector_d        = {reg_wdata[9:7], 7'd0};
            sector_or_all_d = 1'b0;
          end
          CMD_ERASE_CHIP: begin
            mode_d          = ModeEraseSetup;
            sector_d        = '0;
            sector_or_all_d = 1'b1;
          end
          CMD_WRITE_BUF: mode_d = ModeWriteBuffer;
          CMD_ERASE_EXEC, CMD_ERASE_EXEC2: begin
            if (mode_q == ModeEraseSetup) begin
              mode_d                    = ModeBusy;
              pending_d                 = 1'b1;
              write_or_erase_d          = 1'b1;
              status_d[STAT_ERASE_BUSY] = 1'b1;
              status_d[STAT_ERASE_DONE] = 1'b0;
            end
          end
          CMD_EXEC: begin
            if (mode_q == ModeWriteBuffer) begin
              mode_d                    = ModeBusy;
              pending_d                 = 1'b1;
              sector_d                  = reg_wdata[9:0];
              sector_or_all_d           = 1'b0;
              write_or_erase_d          = 1'b0;
              status_d[STAT_WRITE_BUSY] = 1'b1;
              status_d[STAT_WRITE_DONE] = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Page-buffer pipeline: one register stage to the BRAM port.
  logic        bram_wr_q;
  logic [5:0]  bram_addr_q;
  logic [15:0] bram_data_q;
  logic        buf_accept;
  assign buf_accept = buf_write && (mode_q == ModeWriteBuffer);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bram_wr_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_data_q <= '0;
    end else begin
      bram_wr_q <= buf_accept;
      if (buf_accept) begin
        bram_addr_q <= buf_address;
        bram_data_q <= buf_wdata;
      end
    end
  end

  always_comb begin
    reg_rdata = '0;
    if (!reg_address) begin
      reg_rdata = (mode_q == ModeId) ? ID_HI : {24'd0, 4'd0, status_q};
    end else if (mode_q == ModeId) begin
      reg_rdata = ID_LO;
    end
  end

  assign flashram_pending        = pending_q;
  assign flashram_sector         = sector_q;
  assign flashram_sector_or_all  = sector_or_all_q;
  assign flashram_write_or_erase = write_or_erase_q;
  assign flashram_read_mode      = (mode_q == ModeRead);
  assign flashram_write          = bram_wr_q;
  assign flashram_address        = bram_addr_q;
  assign flashram_wdata          = bram_data_q;

endmodule

// File: tb/tb_n64_flashram.sv
module tb_n64_flashram;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        n64_reset;
  logic        reg_write;
  logic        reg_address;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        buf_write;
  logic [5:0]  buf_address;
  logic [15:0] buf_wdata;
  logic        flashram_pending;
  logic        flashram_done;
  logic [9:0]  flashram_sector;
  logic        flashram_sector_or_all;
  logic        flashram_write_or_erase;
  logic        flashram_read_mode;
  logic        flashram_write;
  logic [5:0]  flashram_address;
  logic [15:0] flashram_wdata;

  n64_flashram dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .n64_reset               (n64_reset),
    .reg_write               (reg_write),
    .reg_address             (reg_address),
    .reg_wdata               (reg_wdata),
    .reg_rdata               (reg_rdata),
    .buf_write               (buf_write),
    .buf_address             (buf_address),
    .buf_wdata               (buf_wdata),
    .flashram_pending        (flashram_pending),
    .flashram_done           (flashram_done),
    .flashram_sector         (flashram_sector),
    .flashram_sector_or_all  (flashram_sector_or_all),
    .flashram_write_or_erase (flashram_write_or_erase),
    .flashram_read_mode      (flashram_read_mode),
    .flashram_write          (flashram_write),
    .flashram_address        (flashram_address),
    .flashram_wdata          (flashram_wdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  logic [21:0] sb[$];  // expected {address, data} of BRAM writes

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // BRAM write monitor: every flashram_write pulse must match the scoreboard head.
  always @(negedge clk) begin
    if (reset_n && flashram_write) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        check("buf_unexpected_write", {26'd0, flashram_address}, 32'hFFFF_FFFF);
      end else begin
        logic [21:0] e;
        e = sb.pop_front();
        check("buf_addr_data", {10'd0, flashram_address, flashram_wdata}, {10'd0, e});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic addr, input logic [31:0] data);
    reg_write   = 1'b1;
    reg_address = addr;
    reg_wdata   = data;
    step();
    reg_write   = 1'b0;
  endtask

  task automatic cmd(input logic [31:0] data);
    reg_wr(1'b1, data);
  endtask

  task automatic done_pulse();
    flashram_done = 1'b1;
    step();
    flashram_done = 1'b0;
  endtask

  task automatic rd(input string tag, input logic addr, input logic [31:0] exp);
    reg_address = addr;
    #1;
    check(tag, reg_rdata, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    n64_reset = 1'b0;
    reg_write = 1'b0;
    reg_address = 1'b0;
    reg_wdata = '0;
    buf_write = 1'b0;
    buf_address = '0;
    buf_wdata = '0;
    flashram_done = 1'b0;
    step();
    step();
    check("rst_pending", {31'd0, flashram_pending}, 32'd0);
    check("rst_read_mode", {31'd0, flashram_read_mode}, 32'd1);
    check("rst_sector", {22'd0, flashram_sector}, 32'd0);
    check("rst_flags", {30'd0, flashram_sector_or_all, flashram_write_or_erase}, 32'd0);
    check("rst_bram_wr", {31'd0, flashram_write}, 32'd0);
    rd("rst_status", 1'b0, 32'd0);
    reset_n = 1'b1;
    step();

    // Sector erase.
    cmd(32'h4B00_0085);
    check("setup_no_pending", {31'd0, flashram_pending}, 32'd0);
    cmd(32'h7800_0000);
    check("erase_pending", {31'd0, flashram_pending}, 32'd1);
    check("erase_sector", {22'd0, flashram_sector}, 32'h080);
    check("erase_soa", {31'd0, flashram_sector_or_all}, 32'd0);
    check("erase_woe", {31'd0, flashram_write_or_erase}, 32'd1);
    check("erase_read_mode", {31'd0, flashram_read_mode}, 32'd0);
    rd("erase_status_busy", 1'b0, 32'h02);
    done_pulse();
    check("erase_done_pending", {31'd0, flashram_pending}, 32'd0);
    rd("erase_status_done", 1'b0, 32'h08);
    check("erase_done_mode_status", {31'd0, flashram_read_mode}, 32'd0);
    reg_wr(1'b0, 32'h0);
    rd("status_clear", 1'b0, 32'h00);

    // Page program.
    cmd(32'hB400_0000);
    for (int i = 0; i < 64; i++) begin
      buf_write   = 1'b1;
      buf_address = 6'(i);
      buf_wdata   = 16'hA500 + 16'(i);
      sb.push_back({6'(i), 16'hA500 + 16'(i)});
      step();
    end
    buf_write = 1'b0;
    step();
    check("buf_write_count", wr_cnt, 32'd64);
    check("buf_sb_empty", sb.size(), 32'd0);
    cmd(32'hA500_0123);
    check("prog_pending", {31'd0, flashram_pending}, 32'd1);
    check("prog_sector", {22'd0, flashram_sector}, 32'h123);
    check("prog_woe", {31'd0, flashram_write_or_erase}, 32'd0);
    rd("prog_status_busy", 1'b0, 32'h01);

    // Commands during BUSY are ignored.
    cmd(32'hF000_0000);
    cmd(32'h4B00_0385);
    reg_wr(1'b0, 32'h0);
    check("busy_cmd_pending", {31'd0, flashram_pending}, 32'd1);
    check("busy_cmd_sector", {22'd0, flashram_sector}, 32'h123);
    check("busy_cmd_read_mode", {31'd0, flashram_read_mode}, 32'd0);
    rd("busy_cmd_status", 1'b0, 32'h01);

    // Done and a READ command in the same cycle: done wins.
    flashram_done = 1'b1;
    cmd(32'hF000_0000);
    flashram_done = 1'b0;
    check("prog_done_pending", {31'd0, flashram_pending}, 32'd0);
    check("prog_done_mode_status", {31'd0, flashram_read_mode}, 32'd0);
    rd("prog_status_done", 1'b0, 32'h04);

    // Stray done outside BUSY is ignored.
    done_pulse();
    rd("stray_done_status", 1'b0, 32'h04);

    // buf_write outside WRITE_BUFFER: monitor flags any BRAM write.
    for (int i = 0; i < 4; i++) begin
      buf_write   = 1'b1;
      buf_address = 6'(i);
      buf_wdata   = 16'h5A5A;
      step();
    end
    buf_write = 1'b0;
    step();
    check("buf_guard_count", wr_cnt, 32'd64);

    // Erase exec in READ mode is ignored.
    cmd(32'hF000_0000);
    cmd(32'hD200_0000);
    check("guard_d2_pending", {31'd0, flashram_pending}, 32'd0);
    check("guard_d2_read_mode", {31'd0, flashram_read_mode}, 32'd1);
    rd("read_addr1_zero", 1'b1, 32'd0);

    // ID mode.
    cmd(32'h9900_0000);
    rd("id_hi", 1'b0, 32'h1111_8001);
    rd("id_lo", 1'b1, 32'h00C2_001E);
    check("id_read_mode", {31'd0, flashram_read_mode}, 32'd0);
    cmd(32'hF000_0000);
    check("id_exit_read_mode", {31'd0, flashram_read_mode}, 32'd1);

    // Chip erase with console reset arriving while busy.
    cmd(32'h3C00_0000);
    cmd(32'hD200_0000);
    check("chip_pending", {31'd0, flashram_pending}, 32'd1);
    check("chip_sector", {22'd0, flashram_sector}, 32'd0);
    check("chip_soa", {31'd0, flashram_sector_or_all}, 32'd1);
    rd("chip_status", 1'b0, 32'h06);
    n64_reset = 1'b1;
    step();
    n64_reset = 1'b0;
    step();
    check("n64rst_busy_pending", {31'd0, flashram_pending}, 32'd1);
    check("n64rst_busy_mode", {31'd0, flashram_read_mode}, 32'd0);
    done_pulse();
    check("n64rst_done_pending", {31'd0, flashram_pending}, 32'd0);
    check("n64rst_done_read_mode", {31'd0, flashram_read_mode}, 32'd1);
    rd("n64rst_done_status", 1'b0, 32'h00);

    // Console reset outside BUSY clears status and returns to READ.
    cmd(32'h3C00_0000);
    cmd(32'h7800_0000);
    done_pulse();
    cmd(32'hE100_0000);
    rd("pre_n64rst_status", 1'b0, 32'h08);
    n64_reset = 1'b1;
    step();
    n64_reset = 1'b0;
    check("n64rst_idle_read_mode", {31'd0, flashram_read_mode}, 32'd1);
    rd("n64rst_idle_status", 1'b0, 32'h00);

    // Async reset mid-BUSY takes effect immediately.
    cmd(32'h4B00_0000);
    cmd(32'h7800_0000);
    check("async_pre_pending", {31'd0, flashram_pending}, 32'd1);
    reg_address = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_pending", {31'd0, flashram_pending}, 32'd0);
    check("async_read_mode", {31'd0, flashram_read_mode}, 32'd1);
    check("async_status", reg_rdata, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check("final_sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
